// File: rtl/serial_mod_pkg.sv
// Shared types and helpers for the serial divisibility checker.
package serial_mod_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;

  // Width needed to hold 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 16; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/serial_mod_step.sv
// Modular adder: (a + b + c) mod N for a, b < N, using one conditional subtract.
module mod_step #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_sum
);
  localparam logic [W:0] NW = (W+1)'(N);

  logic [W:0] w_t;

  // a + b + c <= 2N-1, so a single subtract of N fully reduces it.
  assign w_t   = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_c};
  assign o_sum = W'((w_t >= NW) ? (w_t - NW) : w_t);
endmodule

// File: rtl/serial_mod_checker.sv
// Framed serial-bitstream divisibility checker: running remainder mod DIVISOR,
// one registered result per frame, MSB- or LSB-first.
module serial_mod_checker #(
  parameter int  DIVISOR   = 5,
  parameter bit  LSB_FIRST = 1'b0,
  parameter int  LEN_W     = 16,
  localparam int REM_W     = serial_mod_pkg::clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             busy,
  output logic             div_now,
  output logic             res_valid,
  output logic [REM_W-1:0] res_rem,
  output logic             res_div,
  output logic [LEN_W-1:0] res_len,
  output logic             proto_err
);
  import serial_mod_pkg::*;

  localparam logic [REM_W-1:0] POW1 = REM_W'(2 % DIVISOR);

  state_e             r_state, w_nxt;
  logic [REM_W-1:0]   r_rem, w_rem_nxt, w_rem_step, w_addend;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               w_cin, w_start, w_adv, w_fire, w_perr;
  logic               r_res_valid, r_res_div, r_perr;
  logic [REM_W-1:0]   r_res_rem;
  logic [LEN_W-1:0]   r_res_len;

  mod_step #(.N(DIVISOR), .W(REM_W)) u_rem (
    .i_a(r_rem), .i_b(w_addend), .i_c(w_cin), .o_sum(w_rem_step)
  );

  if (LSB_FIRST != serial_mod_pkg::MSB_FIRST) begin : g_lsb
    // pow tracks 2^k mod N, the weight of the next incoming bit.
    logic [REM_W-1:0] r_pow, w_pow_dbl;
    mod_step #(.N(DIVISOR), .W(REM_W)) u_pow (
      .i_a(r_pow), .i_b(r_pow), .i_c(1'b0), .o_sum(w_pow_dbl)
    );
    always_ff @(posedge clk or negedge rst)
      if (!rst)         r_pow <= REM_W'(1);
      else if (w_start) r_pow <= POW1;
      else if (w_adv)   r_pow <= w_pow_dbl;
    assign w_addend = in_bit ? r_pow : '0;
    assign w_cin    = 1'b0;
  end else begin : g_msb
    // 2*rem + bit expressed as rem + rem + carry-in.
    assign w_addend = r_rem;
    assign w_cin    = in_bit;
  end

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_adv   = 1'b0;
    w_fire  = 1'b0;
    w_perr  = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A sof while running aborts the old frame silently, apart from the error strobe.
        w_start = 1'b1;
        w_perr  = (r_state == RUN);
        w_fire  = in_eof;
        w_nxt   = in_eof ? IDLE : RUN;
      end else if (r_state == RUN) begin
        w_adv  = 1'b1;
        w_fire = in_eof;
        if (in_eof) w_nxt = IDLE;
      end else begin
        w_perr = 1'b1;
      end
    end
  end

  always_comb begin
    w_rem_nxt = r_rem;
    w_len_nxt = r_len;
    if (w_start) begin
      w_rem_nxt = REM_W'(in_bit);
      w_len_nxt = LEN_W'(1);
    end else if (w_adv) begin
      w_rem_nxt = w_rem_step;
      w_len_nxt = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_len       <= '0;
      r_res_valid <= 1'b0;
      r_res_rem   <= '0;
      r_res_div   <= 1'b0;
      r_res_len   <= '0;
      r_perr      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_rem       <= w_rem_nxt;
      r_len       <= w_len_nxt;
      r_res_valid <= w_fire;
      r_perr      <= w_perr;
      if (w_fire) begin
        r_res_rem <= w_rem_nxt;
        r_res_div <= (w_rem_nxt == '0);
        r_res_len <= w_len_nxt;
      end
    end

  assign busy      = (r_state == RUN);
  assign div_now   = busy && (r_rem == '0);
  assign res_valid = r_res_valid;
  assign res_rem   = r_res_rem;
  assign res_div   = r_res_div;
  assign res_len   = r_res_len;
  assign proto_err = r_perr;
endmodule

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
- Serial-bitstream divisibility checker, generalised to any DIVISOR ≥ 2.
- Selectable bit order: MSB-first or LSB-first.
- Frames are delimited by start/end markers. A registered result (remainder, divisible flag, bit count) is produced once per frame.
- Sits behind serial receivers in the FSM library. Replaces the fixed divide-by-5 Moore checker.

Parameters:
- DIVISOR, 5, modulus N; legal range 2..255.
- LSB_FIRST, 0, 0 = MSB-first (value = 2·value + bit); 1 = LSB-first (value += bit·2^k).
- LEN_W, 16, width of the per-frame bit counter.
- REM_W, $clog2(DIVISOR), remainder width (localparam, derived).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  qualifies in_bit/in_sof/in_eof this cycle
- in_bit  in  1  serial data bit
- in_sof  in  1  first bit of a frame (with in_valid)
- in_eof  in  1  last bit of a frame (with in_valid)
- busy  out  1  frame in progress
- div_now  out  1  running remainder == 0 while busy (Moore, from registers)
- res_valid  out  1  one-cycle result strobe
- res_rem  out  REM_W  final remainder, held until next result
- res_div  out  1  res_rem == 0, held
- res_len  out  LEN_W  bits in frame, saturating, held
- proto_err  out  1  one-cycle protocol-error strobe

Behaviour:
- Reset (rst=0, async): all registers and outputs clear to 0. busy=0, div_now=0, res_*=0, proto_err=0, pow=1.
- Only beats with in_valid=1 are accepted; with in_valid=0 state holds and the strobes drop to 0.
- Arithmetic:
  - Running remainder rem < N at all times.
  - MSB-first: t = 2·rem + bit (< 2N); rem' = t ≥ N ? t−N : t.
  - LSB-first: also keep pow = 2^k mod N. t = rem + (bit ? pow : 0); rem' = t ≥ N ? t−N : t. pow' = 2·pow reduced the same way.
  - Datapath width is REM_W+1; one conditional subtract per beat, no dividers.
- States: IDLE, RUN.
- IDLE + valid + sof:
  - Start a new frame: rem = bit, pow = 2 mod N, len = 1.
  - Go to RUN, unless eof is also set (1-bit frame): result fires, stay IDLE.
- IDLE + valid + !sof: bit dropped, proto_err=1 for one cycle, state unchanged.
- RUN + valid + !sof: update rem/pow. len increments and saturates at 2^LEN_W−1 (no wrap).
- RUN + valid + sof: current frame aborted with no result and proto_err=1. The new frame starts from this beat as in IDLE.
- eof beat (RUN, or IDLE with sof):
  - The eof bit is included in the result.
  - The next cycle: res_valid=1, res_rem/res_div/res_len loaded. busy=0 and state returns to IDLE.
  - Latency is 1 cycle from eof acceptance to res_valid.
  - A sof on the cycle right after eof is accepted normally; there are no bubbles.
- busy = (state == RUN). div_now = busy && rem == 0.
- res_* hold their values between strobes. Reset mid-frame discards the frame with no result.

Decomposition:
- Package serial_mod_pkg holds:
  - state enum {IDLE, RUN};
  - localparam bit-order constants MSB_FIRST=0, LSB_FIRST=1;
  - function clog2 helper.
- Sub-module mod_step:
  - Combinational (a, b, N) -> (a+b) mod N with a, b < N.
  - Instantiated once for the rem update and, when LSB_FIRST=1, once for the pow doubling.

Test Plan:
- N=5, MSB, frame 1,0,1,0 (10) -> res_valid 1 cycle after eof, res_rem=0, res_div=1, res_len=4. Frame 1,0,1,1 (11) back-to-back -> res_rem=1, res_div=0.
- N=3, LSB, bits 1,1,0,0 (value 3) -> res_rem=0, res_div=1. Bits 0,1,1 (6) -> res_rem=0. Bits 1,0,1 (5) -> res_rem=2.
- N=7, MSB, single beat sof=eof=1, bit=1 -> res_rem=1, res_len=1, busy never asserted. Random 64-bit frames are checked against a reference model (value mod 7).
- Protocol errors:
  - valid bit with no sof in IDLE -> proto_err pulse, no state change.
  - sof mid-frame after 1,1 -> proto_err pulse, no res_valid. The new frame 1,0,1,0 then yields res_rem=0.
- Reset asserted mid-frame (after 3 bits) -> all outputs 0 immediately, asynchronously, before the next clk edge. No res_valid after release. The next frame is evaluated correctly.
- LEN_W=4, 20-bit frame of zeros -> res_len=15 (saturated), res_rem=0, res_div=1. div_now stays 1 throughout.
